// File: rtl/rr_mux_arbiter_if.sv
// Channel bundle between N requesters and the round-robin mux arbiter.
// master drives requests and data; slave (the arbiter) returns grant,
// select and the muxed channel.
interface rr_mux_arbiter_if #(
  parameter int N = 3,
  parameter int W = 2
);
  logic [N-1:0]   req;
  logic [N*W-1:0] idata;
  logic [N-1:0]   gnt;
  logic [1:0]     sel;
  logic [W-1:0]   odata;
  logic           ovalid;
  logic           busy;

  modport master (
    output req, idata,
    input  gnt, sel, odata, ovalid, busy
  );

  modport slave (
    input  req, idata,
    output gnt, sel, odata, ovalid, busy
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select of an N:1 W-bit mux.
// Grant/select are registered; an owner's tenure is capped at MAX_BURST
// cycles whenever another requester is waiting. Handover is gap-free.

// Per-requester slice of the AND-OR output mux: passes this requester's
// data only when it is the granted, still-requesting owner.
module rr_mux_lane #(
  parameter int W   = 2,
  parameter int IDX = 0
) (
  input  logic         busy_i,
  input  logic [1:0]   sel_i,
  input  logic         req_i,
  input  logic [W-1:0] data_i,
  output logic         hit_o,
  output logic [W-1:0] data_o
);
  // Lane is live when it owns the channel and is still requesting.
  always_comb begin
    hit_o  = busy_i & req_i & (sel_i == 2'(IDX));
    data_o = hit_o ? data_i : '0;
  end
endmodule

module rr_mux_arbiter #(
  parameter int N         = 3,
  parameter int W         = 2,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  rr_mux_arbiter_if.slave bus
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q,   cnt_d;
  logic [1:0]   ptr_q,   ptr_d;
  logic [1:0]   sel_q,   sel_d;
  logic [N-1:0] gnt_q,   gnt_d;

  logic         found_any;
  logic [1:0]   found_idx;
  logic [N-1:0] found_oh;
  logic [1:0]   found_nxt;
  logic [N-1:0] sel_oh;
  logic         own_req;
  logic         others;
  int unsigned  scan_idx;

  logic [N-1:0]        lane_hit;
  logic [N-1:0][W-1:0] lane_data;

  // Rotating search: first requester at or after ptr, modulo N. The loop
  // runs from the far end back so the nearest hit is the last one written.
  always_comb begin
    found_any = 1'b0;
    found_idx = '0;
    scan_idx  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      scan_idx = (32'(ptr_q) + 32'(k)) % 32'(N);
      if (bus.req[scan_idx]) begin
        found_any = 1'b1;
        found_idx = 2'(scan_idx);
      end
    end
  end

  // One-hot forms of the search result and current owner, plus the
  // pointer value that would follow a grant to the search result.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      found_oh[i] = (found_idx == 2'(i));
      sel_oh[i]   = (sel_q == 2'(i));
    end
    own_req   = |(bus.req & sel_oh);
    others    = |(bus.req & ~sel_oh);
    found_nxt = (found_idx == 2'(N - 1)) ? 2'd0 : found_idx + 2'd1;
  end

  // Next-state: grant from IDLE, release/preempt handover, or hold with a
  // saturating tenure count. Since ptr sits one past the owner, a search
  // with other requesters present never lands back on the owner.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (found_any) begin
          state_d = OWN;
          gnt_d   = found_oh;
          sel_d   = found_idx;
          cnt_d   = 4'd1;
          ptr_d   = found_nxt;
        end
      end
      OWN: begin
        if (!own_req && !others) begin
          // Released with nobody waiting: park, sel keeps last owner.
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (!own_req || (cnt_q == 4'(MAX_BURST) && others)) begin
          gnt_d = found_oh;
          sel_d = found_idx;
          cnt_d = 4'd1;
          ptr_d = found_nxt;
        end else if (cnt_q != 4'(MAX_BURST)) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wins over everything, including mid-burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      rr_mux_lane #(.W(W), .IDX(i)) u_lane (
        .busy_i (state_q == OWN),
        .sel_i  (sel_q),
        .req_i  (bus.req[i]),
        .data_i (bus.idata[i*W +: W]),
        .hit_o  (lane_hit[i]),
        .data_o (lane_data[i])
      );
    end
  endgenerate

  // OR-combine the lanes: at most one lane is live, all others give zero.
  always_comb begin
    bus.odata = '0;
    for (int i = 0; i < N; i++) bus.odata = bus.odata | lane_data[i];
    bus.ovalid = |lane_hit;
    bus.gnt    = gnt_q;
    bus.sel    = sel_q;
    bus.busy   = (state_q == OWN);
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: a table of per-edge vectors with hand-derived
// expected outputs, fed through a scoreboard queue, plus a mid-cycle check
// of the combinational output gating.
module tb_rr_mux_arbiter;

  localparam logic [5:0] ID = 6'b10_01_00;

  logic clk = 1'b0;
  logic rst;

  rr_mux_arbiter_if #(.N(3), .W(2)) bus ();

  rr_mux_arbiter #(.N(3), .W(2), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [5:0] idata;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       ovalid;
    logic [1:0] odata;
    string      name;
  } vec_t;

  typedef struct {
    logic [8:0] exp;
    string      name;
    int         idx;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic r, input logic [2:0] rq,
                              input logic [5:0] d, input logic [2:0] g,
                              input logic [1:0] s, input logic b,
                              input logic ov, input logic [1:0] od,
                              input string nm);
    vec_t v;
    v.rst = r; v.req = rq; v.idata = d; v.gnt = g; v.sel = s;
    v.busy = b; v.ovalid = ov; v.odata = od; v.name = nm;
    vecs.push_back(v);
  endfunction

  function automatic logic [8:0] outs();
    return {bus.gnt, bus.sel, bus.busy, bus.ovalid, bus.odata};
  endfunction

  task automatic cmp(input string nm, input int idx, input logic [8:0] act,
                     input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got gnt=%b sel=%0d busy=%b ovalid=%b odata=%b want gnt=%b sel=%0d busy=%b ovalid=%b odata=%b",
               nm, idx, act[8:6], act[5:4], act[3], act[2], act[1:0],
               exp[8:6], exp[5:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  initial begin
    int o;
    sb_t e;
    rst = 1'b1;
    bus.req = '0;
    bus.idata = ID;

    // Reset, then a single request, then release to idle.
    add(1, 3'b000, ID, 3'b000, 0, 0, 0, 2'b00, "reset");
    add(0, 3'b001, ID, 3'b001, 0, 1, 1, 2'b00, "single");
    add(0, 3'b000, ID, 3'b000, 0, 0, 0, 2'b00, "release_idle");
    // Round robin with all three requesting: 4 cycles each, 0,1,2,0.
    add(1, 3'b000, ID, 3'b000, 0, 0, 0, 2'b00, "rr_reset");
    for (int i = 0; i < 16; i++) begin
      o = (i / 4) % 3;
      add(0, 3'b111, ID, 3'b001 << o, 2'(o), 1, 1, 2'(o), "round_robin");
    end
    // Early release: owner 1 leaves after 2 cycles with 2 waiting.
    add(0, 3'b110, ID, 3'b010, 1, 1, 1, 2'b01, "early_rel_own1");
    add(0, 3'b110, ID, 3'b010, 1, 1, 1, 2'b01, "early_rel_own1");
    add(0, 3'b100, ID, 3'b100, 2, 1, 1, 2'b10, "early_rel_hand");
    // Owner 2 releases alone: idle with sel held, then ptr wrapped to 0.
    add(0, 3'b000, ID, 3'b000, 2, 0, 0, 2'b00, "wrap_idle");
    add(0, 3'b011, ID, 3'b001, 0, 1, 1, 2'b00, "wrap_grant0");
    add(0, 3'b000, ID, 3'b000, 0, 0, 0, 2'b00, "idle_again");
    // Lone owner keeps the grant; a new requester preempts at once.
    for (int i = 0; i < 10; i++)
      add(0, 3'b010, ID, 3'b010, 1, 1, 1, 2'b01, "lone_owner");
    add(0, 3'b011, ID, 3'b001, 0, 1, 1, 2'b00, "lone_preempt");
    // Build a burst on owner 2 with cnt=3, then reset mid-burst.
    add(0, 3'b100, ID, 3'b100, 2, 1, 1, 2'b10, "burst2_c1");
    add(0, 3'b100, ID, 3'b100, 2, 1, 1, 2'b10, "burst2_c2");
    add(0, 3'b100, ID, 3'b100, 2, 1, 1, 2'b10, "burst2_c3");
    add(1, 3'b100, ID, 3'b000, 0, 0, 0, 2'b00, "mid_reset");
    add(0, 3'b110, ID, 3'b010, 1, 1, 1, 2'b01, "post_reset");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      bus.req = vecs[i].req;
      bus.idata = vecs[i].idata;
      e.exp = {vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].ovalid,
               vecs[i].odata};
      e.name = vecs[i].name;
      e.idx = i;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      cmp(e.name, e.idx, outs(), e.exp);
    end

    // Mid-cycle: owner 1 drops req before the edge -> channel gated off
    // while the registered grant is still held.
    @(negedge clk);
    bus.req = 3'b000;
    #1;
    cmp("comb_gate", 0, outs(), {3'b010, 2'd1, 1'b1, 1'b0, 2'b00});
    // Data follows the owner's slice combinationally.
    bus.req = 3'b010;
    bus.idata = 6'b00_11_00;
    #1;
    cmp("comb_data", 0, outs(), {3'b010, 2'd1, 1'b1, 1'b1, 2'b11});
    bus.idata = 6'b11_00_11;
    #1;
    cmp("comb_data", 1, outs(), {3'b010, 2'd1, 1'b1, 1'b1, 2'b00});

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
